sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 106 ++++++++++
 tb/tb_sdram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-client round-robin arbiter in front of an SDRAM controller.
// Handles command issue, ack timeout with reissue, and read-data return.
module sdram_port_arbiter #(
   parameter int BANK_WIDTH  = 2,
   parameter int ROW_WIDTH   = 12,
   parameter int COL_WIDTH   = 9,
   parameter int DATA_WIDTH  = 32,
   parameter int ACK_TIMEOUT = 15,
   localparam int ADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  c0_req_valid,
   output logic                  c0_req_ready,
   input  logic                  c0_req_we,
   input  logic [ADDR_WIDTH-1:0] c0_req_addr,
   input  logic [DATA_WIDTH-1:0] c0_req_wdata,
   output logic                  c0_rsp_valid,
   output logic [DATA_WIDTH-1:0] c0_rsp_data,
   input  logic                  c1_req_valid,
   output logic                  c1_req_ready,
   input  logic                  c1_req_we,
   input  logic [ADDR_WIDTH-1:0] c1_req_addr,
   input  logic [DATA_WIDTH-1:0] c1_req_wdata,
   output logic                  c1_rsp_valid,
   output logic [DATA_WIDTH-1:0] c1_rsp_data,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic                  rd_ready,
   input  logic                  busy,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  retry
);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic rr_ptr, grant, accept, id, we, timeout, active;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   always_comb begin
      grant   = (c0_req_valid & c1_req_valid) ? rr_ptr : c1_req_valid;
      accept  = reset_n & (state == IDLE) & ~busy & (c0_req_valid | c1_req_valid);
      timeout = (state == WAIT_ACK) & ~busy & (cnt == CW'(ACK_TIMEOUT - 1));
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         IDLE:      state_nxt = accept ? ISSUE : IDLE;
         ISSUE:     state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            cnt_nxt   = busy ? '0 : cnt + CW'(1);
            state_nxt = busy ? WAIT_DONE : (timeout ? ISSUE : WAIT_ACK);
         end
         WAIT_DONE: state_nxt = busy ? WAIT_DONE : (we ? IDLE : RESP);
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rr_ptr      <= 1'b0;
         id          <= 1'b0;
         we          <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         c0_rsp_data <= '0;
         c1_rsp_data <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            we     <= grant ? c1_req_we : c0_req_we;
            addr   <= grant ? c1_req_addr : c0_req_addr;
            wdata  <= grant ? c1_req_wdata : c0_req_wdata;
            id     <= grant;
            rr_ptr <= ~grant;
         end
         // read data is captured on the cycle the controller drops busy
         if (state == WAIT_DONE && !busy && !we) begin
            if (id) c1_rsp_data <= rd_data;
            else    c0_rsp_data <= rd_data;
         end
      end
   end
   always_comb begin
      active       = state != IDLE;
      c0_req_ready = accept & ~grant;
      c1_req_ready = accept & grant;
      wr_addr      = active ? addr : '0;
      rd_addr      = active ? addr : '0;
      wr_data      = active ? wdata : '0;
      wr_en        = (state == ISSUE) & we;
      rd_en        = (state == ISSUE) & ~we;
      rd_ready     = (state == WAIT_DONE) & ~we;
      retry        = (state == ISSUE) & (cnt == CW'(ACK_TIMEOUT));
      c0_rsp_valid = (state == RESP) & ~id;
      c1_rsp_valid = (state == RESP) & id;
   end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed stimulus with queued expected commands, grants
// and responses, checked by an independent negedge monitor.
module tb_sdram_port_arbiter;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        c0_req_valid, c0_req_ready, c0_req_we, c0_rsp_valid;
   logic [22:0] c0_req_addr;
   logic [31:0] c0_req_wdata, c0_rsp_data;
   logic        c1_req_valid, c1_req_ready, c1_req_we, c1_rsp_valid;
   logic [22:0] c1_req_addr;
   logic [31:0] c1_req_wdata, c1_rsp_data;
   logic [22:0] wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;
   logic        wr_en, rd_en, rd_ready, busy, retry;
   int vectors = 0, miscompares = 0, rsp_seen = 0;
   logic [55:0] cmd_q[$];
   logic [32:0] rsp_q[$];
   logic        gnt_q[$];

   sdram_port_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_we(c0_req_we),
      .c0_req_addr(c0_req_addr), .c0_req_wdata(c0_req_wdata),
      .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
      .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_we(c1_req_we),
      .c1_req_addr(c1_req_addr), .c1_req_wdata(c1_req_wdata),
      .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
      .wr_en(wr_en), .rd_en(rd_en), .rd_ready(rd_ready),
      .busy(busy), .rd_data(rd_data), .retry(retry)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int c, input logic v, input logic we, input logic [22:0] a, input logic [31:0] d);
      if (c == 0) begin
         c0_req_valid = v; c0_req_we = we; c0_req_addr = a; c0_req_wdata = d;
      end else begin
         c1_req_valid = v; c1_req_we = we; c1_req_addr = a; c1_req_wdata = d;
      end
   endtask

   // monitor: every command pulse, grant and response strobe consumes one expectation
   always @(negedge clk) begin : mon
      logic [55:0] cmd;
      logic [32:0] rsp;
      if (reset_n) begin
         if (c0_req_ready | c1_req_ready)
            check("one_ready", {63'd0, c0_req_ready & c1_req_ready}, 64'd0);
         if ((c0_req_valid & c0_req_ready) | (c1_req_valid & c1_req_ready)) begin
            if (gnt_q.size() == 0) check("grant_unexpected", gnt_q.size(), 1);
            else check("grant", {63'd0, c1_req_ready}, {63'd0, gnt_q.pop_front()});
         end
         if (wr_en | rd_en) begin
            cmd = {wr_en, wr_en ? wr_addr : rd_addr, wr_data};
            check("one_cmd", {63'd0, wr_en & rd_en}, 64'd0);
            if (cmd_q.size() == 0) check("cmd_unexpected", cmd_q.size(), 1);
            else check("cmd", {8'd0, cmd}, {8'd0, cmd_q.pop_front()});
         end
         if (c0_rsp_valid | c1_rsp_valid) begin
            rsp_seen++;
            rsp = {c1_rsp_valid, c1_rsp_valid ? c1_rsp_data : c0_rsp_data};
            check("one_rsp", {63'd0, c0_rsp_valid & c1_rsp_valid}, 64'd0);
            if (rsp_q.size() == 0) check("rsp_unexpected", rsp_q.size(), 1);
            else check("rsp", {31'd0, rsp}, {31'd0, rsp_q.pop_front()});
         end
      end
   end

   // single-client transaction; pre = cycles of busy held high in IDLE before release
   task automatic txn(input int c, input logic we, input logic [22:0] a, input logic [31:0] d,
                      input int pre, input int blen, input logic [31:0] rdat);
      int n;
      cmd_q.push_back({we, a, d});
      gnt_q.push_back(c[0]);
      if (!we) rsp_q.push_back({c[0], rdat});
      busy = pre > 0;
      drive(c, 1'b1, we, a, d);
      for (int i = 0; i < pre; i++) begin
         @(negedge clk);
         check("busy_gate", {62'd0, c0_req_ready, c1_req_ready}, 64'd0);
         tick();
      end
      busy = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(c[0] ? c1_req_ready : c0_req_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", n, 0);
      tick();
      drive(c, 1'b0, we, a, d);
      check("issue_pulse", {62'd0, wr_en, rd_en}, we ? 64'd2 : 64'd1);
      tick();
      busy = 1'b1;
      repeat (blen) tick();
      check("rd_ready", {63'd0, rd_ready}, {63'd0, !we});
      busy = 1'b0;
      rd_data = rdat;
      tick();
      if (!we) begin
         check("rsp_strobe", {62'd0, c1_rsp_valid, c0_rsp_valid}, c[0] ? 64'd2 : 64'd1);
         tick();
      end
      check("idle_addr", {18'd0, wr_addr, rd_addr}, 64'd0);
   endtask

   initial begin
      int n, seen;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      busy = 1'b0;
      rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {62'd0, c0_req_ready, c1_req_ready}, 64'd0);
      check("rst_en", {61'd0, wr_en, rd_en, retry}, 64'd0);
      check("rst_rsp_valid", {62'd0, c0_rsp_valid, c1_rsp_valid}, 64'd0);
      check("rst_addr", {18'd0, wr_addr, rd_addr}, 64'd0);
      check("rst_wdata", {32'd0, wr_data}, 64'd0);
      check("rst_rd_ready", {63'd0, rd_ready}, 64'd0);
      check("rst_rsp_data", {c0_rsp_data, c1_rsp_data}, 64'd0);
      reset_n = 1'b1;
      tick();

      txn(0, 1'b1, 23'h012345, 32'hDEADBEEF, 0, 3, 32'h0);
      txn(1, 1'b0, 23'h000100, 32'h0, 0, 2, 32'hCAFEF00D);
      txn(0, 1'b1, 23'h000200, 32'h0F0F0F0F, 5, 1, 32'h0);
      check("rsp1_hold", {32'd0, c1_rsp_data}, 64'hCAFEF00D);
      check("rsp0_hold", {32'd0, c0_rsp_data}, 64'd0);

      // ack timeout: busy never rises after the first rd_en
      cmd_q.push_back({1'b0, 23'h5A5A5A, 32'h0});
      cmd_q.push_back({1'b0, 23'h5A5A5A, 32'h0});
      gnt_q.push_back(1'b0);
      rsp_q.push_back({1'b0, 32'h0BADF00D});
      seen = rsp_seen;
      drive(0, 1'b1, 1'b0, 23'h5A5A5A, 32'h0);
      @(negedge clk);
      check("to_ready", {63'd0, c0_req_ready}, 64'd1);
      tick();
      drive(0, 1'b0, 1'b0, 23'h5A5A5A, 32'h0);
      check("to_first", {62'd0, rd_en, retry}, 64'd2);
      tick();
      repeat (14) tick();
      check("to_no_early", {62'd0, rd_en, retry}, 64'd0);
      tick();
      check("to_reissue", {62'd0, rd_en, retry}, 64'd3);
      tick();
      busy = 1'b1;
      check("to_retry_once", {62'd0, rd_en, retry}, 64'd0);
      tick();
      busy = 1'b0;
      rd_data = 32'h0BADF00D;
      tick();
      check("to_rsp", {63'd0, c0_rsp_valid}, 64'd1);
      tick();
      check("to_rsp_done", {63'd0, c0_rsp_valid}, 64'd0);
      check("to_rsp_count", rsp_seen - seen, 1);

      // contention: both clients hold valid from reset
      reset_n = 1'b0;
      tick();
      drive(0, 1'b1, 1'b1, 23'h000010, 32'h11111111);
      drive(1, 1'b1, 1'b1, 23'h000020, 32'h22222222);
      for (int i = 0; i < 4; i++) begin
         gnt_q.push_back(i[0]);
         cmd_q.push_back(i[0] ? {1'b1, 23'h000020, 32'h22222222} : {1'b1, 23'h000010, 32'h11111111});
      end
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         @(negedge clk);
         while (!(c0_req_ready | c1_req_ready) && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("cont_wait", n, 0);
         tick();
         tick();
         busy = 1'b1;
         tick();
         busy = 1'b0;
         tick();
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      tick();

      // reset during WAIT_DONE of a read discards it
      cmd_q.push_back({1'b0, 23'h7FFFFF, 32'h0});
      gnt_q.push_back(1'b1);
      drive(1, 1'b1, 1'b0, 23'h7FFFFF, 32'h0);
      @(negedge clk);
      check("rr_ready", {63'd0, c1_req_ready}, 64'd1);
      tick();
      drive(1, 1'b0, 1'b0, 23'h7FFFFF, 32'h0);
      tick();
      busy = 1'b1;
      tick();
      check("pre_rst_rd_ready", {63'd0, rd_ready}, 64'd1);
      seen = rsp_seen;
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_ctl", {56'd0, c0_req_ready, c1_req_ready, wr_en, rd_en, c0_rsp_valid, c1_rsp_valid, rd_ready, retry}, 64'd0);
      check("mid_rst_addr", {18'd0, wr_addr, rd_addr}, 64'd0);
      check("mid_rst_wdata", {32'd0, wr_data}, 64'd0);
      check("mid_rst_rsp_data", {c0_rsp_data, c1_rsp_data}, 64'd0);
      busy = 1'b0;
      rd_data = 32'h55AA55AA;
      cmd_q.push_back({1'b1, 23'h000ABC, 32'h12345678});
      gnt_q.push_back(1'b0);
      drive(0, 1'b1, 1'b1, 23'h000ABC, 32'h12345678);
      @(negedge clk);
      check("rst_gate", {63'd0, c0_req_ready}, 64'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {63'd0, c0_req_ready}, 64'd1);
      tick();
      drive(0, 1'b0, 1'b1, 23'h000ABC, 32'h12345678);
      check("post_rst_wr", {63'd0, wr_en}, 64'd1);
      tick();
      busy = 1'b1;
      tick();
      busy = 1'b0;
      repeat (4) tick();
      check("no_stale_rsp", rsp_seen - seen, 0);

      check("cmd_q_drained", cmd_q.size(), 0);
      check("rsp_q_drained", rsp_q.size(), 0);
      check("gnt_q_drained", gnt_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
